// File: rtl/reg_wr_arbiter_if.sv
// Write-port bundle between the two register-file write requesters and the arbiter.
// The arbiter takes the slave view; requesters and observers take the master view.
interface reg_wr_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 32
);
    logic                  freeze;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [REG_WIDTH-1:0]  wb_data;
    logic                  wb_ready;
    logic                  dbg_valid;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [REG_WIDTH-1:0]  dbg_data;
    logic                  dbg_ready;
    logic                  RegWEn;
    logic [ADDR_WIDTH-1:0] AddrD;
    logic [REG_WIDTH-1:0]  DataD;
    logic [15:0]           wr_count;

    modport master (
        output freeze,
        output wb_valid, wb_addr, wb_data,
        output dbg_valid, dbg_addr, dbg_data,
        input  wb_ready, dbg_ready,
        input  RegWEn, AddrD, DataD, wr_count
    );

    modport slave (
        input  freeze,
        input  wb_valid, wb_addr, wb_data,
        input  dbg_valid, dbg_addr, dbg_data,
        output wb_ready, dbg_ready,
        output RegWEn, AddrD, DataD, wr_count
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Two-requester register-file write arbiter with one-cycle registered write port.
// Define REG_WR_ARB_RR_EN for round-robin contention; default is fixed priority to writeback.
module reg_wr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 32
) (
    input logic            clk,
    input logic            reset,
    reg_wr_arbiter_if.slave bus
);

    typedef enum logic {
        PTR_WB  = 1'b0,
        PTR_DBG = 1'b1
    } ptr_e;

    ptr_e                  r_ptr;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0]  r_data;
    logic [15:0]           r_count;

    logic                  w_wb_grant;
    logic                  w_dbg_grant;
    logic                  w_xfer;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [REG_WIDTH-1:0]  w_sel_data;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // Grant decision: nothing while in reset or frozen, otherwise sole requester or contention policy.
    always_comb begin
        w_wb_grant  = 1'b0;
        w_dbg_grant = 1'b0;
        if (!reset && !bus.freeze) begin
            if (bus.wb_valid && bus.dbg_valid) begin
`ifdef REG_WR_ARB_RR_EN
                if (r_ptr == PTR_WB) begin
                    w_dbg_grant = 1'b1;
                end else begin
                    w_wb_grant = 1'b1;
                end
`else
                w_wb_grant = 1'b1;
`endif
            end else if (bus.wb_valid) begin
                w_wb_grant = 1'b1;
            end else if (bus.dbg_valid) begin
                w_dbg_grant = 1'b1;
            end else begin
                w_wb_grant  = 1'b0;
                w_dbg_grant = 1'b0;
            end
        end else begin
            w_wb_grant  = 1'b0;
            w_dbg_grant = 1'b0;
        end
    end

    // Winner's payload, and whether the transfer actually writes (x0 is swallowed).
    always_comb begin
        w_sel_addr = bus.wb_addr;
        w_sel_data = bus.wb_data;
        if (w_dbg_grant) begin
            w_sel_addr = bus.dbg_addr;
            w_sel_data = bus.dbg_data;
        end else begin
            w_sel_addr = bus.wb_addr;
            w_sel_data = bus.wb_data;
        end
        w_xfer   = w_wb_grant | w_dbg_grant;
        w_commit = w_xfer && (w_sel_addr != {ADDR_WIDTH{1'b0}});
    end

    // Registered write port and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_data  <= {REG_WIDTH{1'b0}};
            r_count <= 16'd0;
        end else begin
            r_wen <= w_commit;
            if (w_commit) begin
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_count <= sat_inc16(r_count);
            end else begin
                r_addr  <= r_addr;
                r_data  <= r_data;
                r_count <= r_count;
            end
        end
    end

    // Last-grant pointer; moves on every transfer, including writes to x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= PTR_WB;
        end else if (w_xfer) begin
            r_ptr <= w_dbg_grant ? PTR_DBG : PTR_WB;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign bus.wb_ready  = w_wb_grant;
    assign bus.dbg_ready = w_dbg_grant;
    assign bus.RegWEn    = r_wen;
    assign bus.AddrD     = r_addr;
    assign bus.DataD     = r_data;
    assign bus.wr_count  = r_count;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: stimulus pushes expected post-edge write-port state,
// a monitor pops and compares one cycle later.
module tb_reg_wr_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_wr_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(DW)) bus ();
    reg_wr_arbiter #(.ADDR_WIDTH(AW), .REG_WIDTH(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [15:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // reference model state: spec-level view of the register-file write port
    int            m_last;
    int            m_count;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_last  = 0;
        m_count = 0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    task automatic drive_idle();
        bus.freeze    = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_data  = '0;
    endtask

    // Monitor: one cycle after each stimulus cycle, compare the write port with the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_port", {bus.RegWEn, bus.AddrD, bus.DataD, bus.wr_count}, e);
        end
    end

    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic fz);
        int            who;
        logic [1:0]    exp_rdy;
        logic [AW-1:0] sa;
        exp_t          e;
        @(posedge clk);
        #2;
        bus.freeze    = fz;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.dbg_valid = dv;
        bus.dbg_addr  = da;
        bus.dbg_data  = dd;
        #1;
        who = -1;
        if (!fz) begin
            if (wv && dv) begin
`ifdef REG_WR_ARB_RR_EN
                who = 1 - m_last;
`else
                who = 0;
`endif
            end else if (wv) begin
                who = 0;
            end else if (dv) begin
                who = 1;
            end
        end
        exp_rdy = {who == 0, who == 1};
        check("ready", {62'd0, bus.wb_ready, bus.dbg_ready}, {62'd0, exp_rdy});
        e.wen = 1'b0;
        if (who >= 0) begin
            m_last = who;
            sa = (who == 1) ? da : wa;
            if (sa != '0) begin
                e.wen  = 1'b1;
                m_addr = sa;
                m_data = (who == 1) ? dd : wd;
                if (m_count < 65535) m_count++;
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        e.cnt  = m_count[15:0];
        exp_q.push_back(e);
    endtask

    initial begin
        logic [DW-1:0] r;
        reset = 1'b1;
        drive_idle();
        model_clear();
        #12;
        check("reset_outputs", {bus.RegWEn, bus.AddrD, bus.DataD, bus.wr_count}, 64'd0);
        bus.wb_valid  = 1'b1;
        bus.dbg_valid = 1'b1;
        #1;
        check("ready_in_reset", {62'd0, bus.wb_ready, bus.dbg_ready}, 64'd0);
        drive_idle();
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // single writeback request, then an x0 write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

        // debug-only grant leaves the pointer on requester 1, then 4 cycles of contention
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA5A5_0003, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 32'h1000_0000 + i, 1'b1, 5'd2, 32'h2000_0000 + i, 1'b0);
        end

        // freeze with both valid, then resume from the held pointer
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd4, 32'h4444_0000 + i, 1'b1, 5'd6, 32'h6666_0000 + i, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 5'd4, 32'h4444_1000 + i, 1'b1, 5'd6, 32'h6666_1000 + i, 1'b0);
        end

        // mid-stream reset between edges, with a write accepted in the same cycle
        step(1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd11;
        bus.wb_data  = 32'hBBBB_BBBB;
        #1;
        check("ready_before_reset", {62'd0, bus.wb_ready, bus.dbg_ready}, 64'd2);
        #1;
        reset  = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check("reset_async", {bus.RegWEn, bus.AddrD, bus.DataD, bus.wr_count}, 64'd0);
        check("ready_in_reset2", {62'd0, bus.wb_ready, bus.dbg_ready}, 64'd0);
        @(posedge clk);
        #4;
        reset = 1'b0;
        drive_idle();
        model_clear();
        @(posedge clk);
        #1;
        check("no_pulse_after_reset", {bus.RegWEn, bus.AddrD, bus.DataD, bus.wr_count}, 64'd0);
        mon_en = 1'b1;

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom;
            step(r[0], r[1] ? 5'($urandom_range(0, 3)) : 5'($urandom), $urandom,
                 r[2], r[3] ? 5'($urandom_range(0, 3)) : 5'($urandom), $urandom,
                 (r[6:4] == 3'd0));
        end

        // drive the counter into saturation
        for (int i = 0; i < 65537; i++) begin
            step(1'b1, 5'd7, i, 1'b0, 5'd0, 32'd0, 1'b0);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;
        check("count_saturated", {48'd0, bus.wr_count}, {48'd0, 16'hFFFF});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter REG_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port freeze  input  1  core stall; no grants while high.
REQ-006 SHALL have port wb_valid  input  1  requester 0 (core writeback) write request.
REQ-007 SHALL have port wb_addr  input  ADDR_WIDTH  requester 0 destination index.
REQ-008 SHALL have port wb_data  input  REG_WIDTH  requester 0 write data.
REQ-009 SHALL have port wb_ready  output  1  requester 0 grant, combinational.
REQ-010 SHALL have port dbg_valid  input  1  requester 1 (debug/late load) write request.
REQ-011 SHALL have port dbg_addr  input  ADDR_WIDTH  requester 1 destination index.
REQ-012 SHALL have port dbg_data  input  REG_WIDTH  requester 1 write data.
REQ-013 SHALL have port dbg_ready  output  1  requester 1 grant, combinational.
REQ-014 SHALL have port RegWEn  output  1  registered write enable to register file.
REQ-015 SHALL have port AddrD  output  ADDR_WIDTH  registered write index.
REQ-016 SHALL have port DataD  output  REG_WIDTH  registered write data.
REQ-017 SHALL have port wr_count  output  16  saturating count of committed non-x0 writes.

Function
REQ-018 SHALL transfer a request when valid and ready are both high in the same cycle.
REQ-019 SHALL assert at most one of wb_ready/dbg_ready per cycle; ready is never asserted without the matching valid.
REQ-020 SHALL hold both ready outputs low while freeze is high; the arbitration pointer SHALL NOT change during freeze.
REQ-021 SHALL, when only one requester is valid and freeze is low, grant that requester in the same cycle.
REQ-022 SHALL, when both are valid, grant per REQ-033/REQ-034.
REQ-023 SHALL register the granted addr/data into AddrD/DataD on the next rising edge; RegWEn SHALL be high for exactly that one cycle (latency 1).
REQ-024 SHALL accept a granted write to index 0 (ready high) but leave RegWEn low for it; AddrD/DataD SHALL hold their previous values.
REQ-025 SHALL drive RegWEn low in any cycle following a cycle with no transfer; AddrD/DataD SHALL hold their last values.
REQ-026 SHALL sustain one committed write per cycle with back-to-back grants.
REQ-027 SHALL increment wr_count by 1 per cycle in which RegWEn is high, saturating at 16'hFFFF.
REQ-028 SHALL keep a 1-bit last-grant pointer: 0 = requester 0 last granted, 1 = requester 1 last granted; it updates only on a transfer, including x0 transfers.

Reset
REQ-029 SHALL, on reset high, immediately clear RegWEn, AddrD, DataD, wr_count and the pointer to 0, independent of clk.
REQ-030 SHALL hold wb_ready and dbg_ready low while reset is high.
REQ-031 SHALL discard a write accepted in the cycle reset asserts; no RegWEn pulse for it after reset release.
REQ-032 SHALL accept grants from the first rising edge at which reset is low.

Configuration
REQ-033 SHALL, with macro REG_WR_ARB_RR_EN defined, resolve contention round-robin: grant the requester not recorded by the pointer.
REQ-034 SHALL, without REG_WR_ARB_RR_EN, resolve contention fixed-priority: requester 0 always wins; the pointer is still maintained but unused.

Verification
REQ-035 SHALL cover: wb_valid=1, wb_addr=5, wb_data=32'hDEADBEEF, dbg_valid=0 -> wb_ready=1 same cycle; next cycle RegWEn=1, AddrD=5, DataD=32'hDEADBEEF, wr_count=1.
REQ-036 SHALL cover: both valid for 4 cycles, addrs 1/2 -> RR_EN: AddrD sequence 1,2,1,2; without RR_EN: 1,1,1,1 with dbg_ready=0 throughout.
REQ-037 SHALL cover: wb_valid=1, wb_addr=0, wb_data=32'h1234 -> wb_ready=1, next cycle RegWEn=0, wr_count unchanged.
REQ-038 SHALL cover: freeze=1 with both valid for 3 cycles -> both ready=0, RegWEn=0; freeze released -> grant resumes from unchanged pointer.
REQ-039 SHALL cover: reset pulsed mid-stream after a grant, between clock edges -> outputs and wr_count read 0 immediately, no RegWEn pulse after release.
REQ-040 SHALL cover: wr_count preloaded near 16'hFFFF via 65535+ writes, then 2 more writes -> wr_count stays 16'hFFFF.
